// File: rtl/seq_det_pkg.sv
`default_nettype none
// ============================================================================
// Module  : seq_det_pkg
// Purpose : Shared state type and the elaboration-time transition table functions
//           for the Moore sequence detector.
// Revision: 1.0 - initial release
// ============================================================================
package seq_det_pkg;

  localparam int ST_MAX_W = 5;  // enough for PAT_W up to 16 (17 states)
  localparam int PAT_MAX  = 16;

  typedef logic [ST_MAX_W-1:0] state_t;

  function automatic int state_w(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

  // Longest proper prefix of the pattern that is also a suffix of it.
  function automatic int border(input logic [PAT_MAX-1:0] pat, input int pat_w);
    int best;
    bit ok;
    best = 0;
    for (int l = 1; l < pat_w; l++) begin
      ok = 1'b1;
      for (int i = 0; i < l; i++) begin
        if (pat[pat_w-1-i] != pat[l-1-i]) ok = 1'b0;
      end
      if (ok) best = l;
    end
    return best;
  endfunction

  function automatic state_t next_state(input logic [PAT_MAX-1:0] pat, input int pat_w,
                                        input int k, input logic b, input logic overlap);
    int   kk;
    int   res;
    int   s;
    bit   ok;
    logic sbit;
    kk  = (k >= pat_w) ? (overlap ? border(pat, pat_w) : 0) : k;
    res = 0;
    // Candidate string is the kk matched pattern bits followed by b.
    for (int j = 1; j <= kk + 1; j++) begin
      ok = 1'b1;
      for (int i = 0; i < j; i++) begin
        s    = kk + 1 - j + i;
        sbit = (s == kk) ? b : pat[pat_w-1-s];
        if (pat[pat_w-1-i] != sbit) ok = 1'b0;
      end
      if (ok) res = j;
    end
    return state_t'(res);
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_det_sat_cnt.sv
`default_nettype none
// ============================================================================
// Module  : seq_det_sat_cnt
// Purpose : Saturating up-counter with sticky saturation flag; clear beats increment.
// Revision: 1.0 - initial release
// ============================================================================
module seq_det_sat_cnt
  import seq_det_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             sat
);

  localparam logic [CNT_W-1:0] C_MAX = '1;

  logic [CNT_W-1:0] r_cnt;
  logic             r_sat;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      r_cnt <= '0;
      r_sat <= 1'b0;
    end else if (inc && (r_cnt != C_MAX)) begin
      r_cnt <= r_cnt + 1'b1;
      if (r_cnt == C_MAX - 1'b1) r_sat <= 1'b1;
    end
  end

  assign cnt = r_cnt;
  assign sat = r_sat;

endmodule
`default_nettype wire

// File: rtl/seq_moore_det.sv
`default_nettype none
// ============================================================================
// Module  : seq_moore_det
// Purpose : Parameterised Moore serial-pattern detector with optional saturating
//           match counter (enabled by defining SEQ_MOORE_DET_CNT_EN).
// Revision: 1.0 - initial release
// ============================================================================
module seq_moore_det
  import seq_det_pkg::*;
#(
  parameter int               PAT_W   = 3,
  parameter logic [PAT_W-1:0] PATTERN = 3'b001,
  parameter int               OVERLAP = 1,
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inp,
  input  logic             inp_valid,
  input  logic             clear_cnt,
  output logic             det,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  localparam int                 SW     = state_w(PAT_W);
  localparam int                 TBL_N  = 2 ** (SW + 1);
  localparam logic [PAT_MAX-1:0] C_PAT  = PAT_MAX'(PATTERN);
  localparam logic [SW-1:0]      C_LAST = SW'(PAT_W);

  logic [SW-1:0] w_ns_tbl [TBL_N];
  logic [SW-1:0] w_ns;
  logic          w_hit;
  logic [SW-1:0] r_state;
  logic          r_det;

  // Table indexed by {state, bit}; codes above S[PAT_W] are unreachable.
  for (genvar e = 0; e < TBL_N; e++) begin : g_tbl
    localparam int     K  = e / 2;
    localparam int     B  = e % 2;
    localparam state_t NS = (K <= PAT_W) ?
                            next_state(C_PAT, PAT_W, K, (B != 0), (OVERLAP != 0)) : '0;
    assign w_ns_tbl[e] = NS[SW-1:0];
  end

  assign w_ns  = w_ns_tbl[{r_state, inp}];
  assign w_hit = inp_valid && (w_ns == C_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= '0;
      r_det   <= 1'b0;
    end else if (inp_valid) begin
      r_state <= w_ns;
      r_det   <= (w_ns == C_LAST);
    end
  end

  assign det = r_det;

`ifdef SEQ_MOORE_DET_CNT_EN
  seq_det_sat_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_hit),
    .clr   (clear_cnt),
    .cnt   (match_cnt),
    .sat   (cnt_sat)
  );
`else
  logic w_unused_cnt;
  assign w_unused_cnt = clear_cnt ^ w_hit;
  assign match_cnt    = '0;
  assign cnt_sat      = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/seq_moore_det.md
SEQ_MOORE_DET -- requirements
Module: seq_moore_det

Interface
REQ-001 Parameter PAT_W, default 3: pattern length in bits, legal range 2..16.
REQ-002 Parameter PATTERN, default 3'b001: pattern; PATTERN[PAT_W-1] is the first bit received.
REQ-003 Parameter OVERLAP, default 1: 1 = overlapping detection, 0 = non-overlapping detection.
REQ-004 Parameter CNT_W, default 8: width of the match counter, legal range 1..32.
REQ-005 clk  input  1  rising-edge clock; single clock domain.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 inp  input  1  serial data bit.
REQ-008 inp_valid  input  1  qualifies inp; the bit is consumed on a rising edge with inp_valid=1.
REQ-009 clear_cnt  input  1  synchronous clear of match_cnt and cnt_sat.
REQ-010 det  output  1  Moore detect flag, decoded from the present state only.
REQ-011 match_cnt  output  CNT_W  number of detections since reset or clear.
REQ-012 cnt_sat  output  1  match_cnt has saturated at all-ones.

Function
REQ-013 State machine SHALL have PAT_W+1 states S0..S[PAT_W]; Sk means the last k consumed bits equal the first k pattern bits.
REQ-014 Next state from Sk on bit b (k<PAT_W) SHALL be the longest j such that the first j pattern bits equal the suffix of (matched prefix, b); the table is computed at elaboration.
REQ-015 From S[PAT_W] with OVERLAP=1, the next state SHALL use the longest proper border of PATTERN as k; with OVERLAP=0, it SHALL be computed as from S0.
REQ-016 When inp_valid=0, the state SHALL hold and det SHALL hold its value.
REQ-017 det SHALL be 1 exactly while the state is S[PAT_W], i.e. one cycle after the last pattern bit is consumed.
REQ-018 match_cnt SHALL increment by 1 on every valid-bit transition into S[PAT_W], including S[PAT_W]->S[PAT_W] re-entry.
REQ-019 At all-ones, match_cnt SHALL hold; cnt_sat SHALL assert in the cycle the counter reaches all-ones and remain high until clear_cnt or reset.
REQ-020 clear_cnt SHALL have priority over a simultaneous increment; the result is match_cnt=0 and cnt_sat=0.
REQ-021 clear_cnt SHALL NOT affect the state or det.
REQ-022 With the defaults, the sequence S0..S3 SHALL equal the legacy 001 detector cycle for cycle.

Reset
REQ-023 On reset=1 at a rising edge, the state SHALL become S0, and det, match_cnt and cnt_sat SHALL become 0.
REQ-024 reset SHALL override inp_valid and clear_cnt.
REQ-025 A partial match in progress when reset is asserted SHALL be discarded.

Configuration
REQ-026 Macro SEQ_MOORE_DET_CNT_EN defined: the match counter and saturation logic are present as specified in REQ-018 to REQ-020.
REQ-027 Macro SEQ_MOORE_DET_CNT_EN undefined:
- no counter flops are synthesised;
- match_cnt and cnt_sat are tied to 0;
- clear_cnt is ignored;
- det behaviour is unchanged.

Structure
REQ-028 Package seq_det_pkg SHALL hold:
- the state-width constant function clog2(PAT_W+1);
- the state typedef;
- the elaboration-time border/next-state table function.
REQ-029 The saturating counter SHALL be sub-module seq_det_sat_cnt (parameter CNT_W; ports clk, reset, inc, clr, cnt, sat).

Verification
REQ-030 Defaults, inp stream 0,0,1,0,0,1 all valid -> det high in the cycles after bits 3 and 6; match_cnt=2.
REQ-031 PAT_W=4, PATTERN=4'b1010, OVERLAP=1, stream 1,0,1,0,1,0 -> det high after bits 4 and 6; match_cnt=2.
REQ-032 Same configuration as REQ-031 with OVERLAP=0 -> det high after bit 4 only; match_cnt=1.
REQ-033 Defaults, stream 0,0 then inp_valid=0 for 5 cycles with inp toggling, then 1 -> det rises one cycle after the 1; no false detection during the stall.
REQ-034 CNT_W=2, four detections -> match_cnt sequence 1,2,3,3; cnt_sat rises with the third detection; clear_cnt asserted in the same cycle as a detection -> match_cnt=0, cnt_sat=0.
REQ-035 reset asserted after stream 0,0 -> state S0 and det=0; a subsequent 1 does not detect, and 0,0,1 does.
